// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl_if
// Brief    : Operand/result handshake bundle for the nibble-serial adder.
//            The master drives operands and out_ready. The slave (adder)
//            drives in_ready, the result and status.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
) ();

  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Brief    : Multi-precision add/subtract sequencer around one 4-bit adder
//            slice. It processes one nibble per clock, LSB first, and holds
//            the carry in a register between nibbles.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_adder_ctrl_if.slave  bus
);

  localparam int NIBBLES = WIDTH / 4;
  // The index must hold at least one bit, even when WIDTH == 4.
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // For subtraction, the captured B is already inverted and the carry is
  // pre-set. The slice therefore only ever adds.
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             carry_q, carry_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic [IDX_W-1:0] idx_q,   idx_d;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [4:0] slice;
  logic       last_nib;

  // Select the current nibble pair and run the 4-bit full-adder slice.
  assign a_nib    = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib    = b_q[{idx_q, 2'b00} +: 4];
  assign slice    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  assign last_nib = (idx_q == LAST_IDX);

  // Handshake and status come straight from the state, so an asynchronous
  // reset returns them to their idle values without needing a clock.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the accept.
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice[3:0];
        carry_d                    = slice[4];
        idx_d                      = idx_q + IDX_W'(1);
        if (last_nib) begin
          cout_d  = slice[4];
          // Signed overflow: both operands share a sign bit that the result
          // does not have. For subtraction, this uses the inverted B.
          ovf_d   = ( a_q[WIDTH-1] &  b_q[WIDTH-1] & ~slice[3]) |
                    (~a_q[WIDTH-1] & ~b_q[WIDTH-1] &  slice[3]);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Self-checking bench for nibble_serial_adder_ctrl. It uses
//            directed vectors plus randomized traffic, compared against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract on the full operands.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 output logic [W-1:0] s, output logic co, output logic ov);
    longint m, ua, ub, sa, sb, r, sr;
    m  = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - m : ua;
    sb = b[W-1] ? ub - m : ub;
    if (!sub) begin
      r  = ua + ub + longint'(cin);
      co = (r >= m);
      sr = sa + sb + longint'(cin);
    end else begin
      r  = ua - ub - longint'(cin);
      co = (r >= 0);
      sr = sa - sb - longint'(cin);
    end
    s  = r[W-1:0];
    ov = (sr > (m / 2 - 1)) || (sr < -(m / 2));
  endfunction

  // Transaction-level expectation of the block's externally visible phase.
  int          m_phase = P_IDLE;
  int          m_left  = 0;
  logic [W-1:0] m_sum  = '0;
  logic        m_cout  = 1'b0;
  logic        m_ovf   = 1'b0;

  // Compare every cycle, then advance the model using the inputs the next edge sees.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs",
            {bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.ovf, bus.sum},
            {1'b1, 4'b0000, {W{1'b0}}});
      m_phase = P_IDLE;
    end else begin
      check("ready_valid_exclusive", bus.in_ready & bus.out_valid, 0);
      check("in_ready",  bus.in_ready,  (m_phase == P_IDLE));
      check("out_valid", bus.out_valid, (m_phase == P_DONE));
      check("busy",      bus.busy,      (m_phase != P_IDLE));
      if (m_phase == P_DONE)
        check("result_vs_model", {bus.cout, bus.ovf, bus.sum}, {m_cout, m_ovf, m_sum});
      case (m_phase)
        P_IDLE: if (bus.in_valid) begin
          ref_op(bus.a, bus.b, bus.cin, bus.sub, m_sum, m_cout, m_ovf);
          m_left  = N;
          m_phase = P_RUN;
        end
        P_RUN: begin
          m_left--;
          if (m_left == 0) m_phase = P_DONE;
        end
        default: if (bus.out_ready) m_phase = P_IDLE;
      endcase
    end
  end

  // Present operands until accepted; return one ns after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    bit acc = 1'b0;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("accept_timeout", acc, 1);
    @(posedge clk); #1;
    // Scramble inputs; the operation in flight must not see these.
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
  endtask

  // Wait exactly N edges after accept (with in_valid noise), then out_valid must be high.
  task automatic wait_result(input bit lit, input logic [W-1:0] es, input logic ec,
                             input logic eo, input string name);
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    check({name, "_latency"}, bus.out_valid, 1);
    if (lit) begin
      check({name, "_sum"},  bus.sum,  es);
      check({name, "_cout"}, bus.cout, ec);
      check({name, "_ovf"},  bus.ovf,  eo);
    end
  endtask

  // Stall the consumer, poking in_valid with new operands that must be ignored.
  task automatic hold_result(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a = W'($urandom); bus.b = W'($urandom);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic take_result();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("drain_in_ready", bus.in_ready, 1);
  endtask

  // Directed op: pin the model to a hand value, then the DUT to the same value.
  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string name);
    logic [W-1:0] ms;
    logic mc, mo;
    ref_op(a, b, cin, sub, ms, mc, mo);
    check({name, "_model"}, {mc, mo, ms}, {ec, eo, es});
    start_op(a, b, cin, sub);
    wait_result(1'b1, es, ec, eo, name);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    directed(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");    take_result();
    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple");   take_result();
    directed(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "add_cin");      take_result();
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf_pos");  take_result();
    directed(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_ovf_neg");  take_result();
    directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");   take_result();
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");      take_result();

    // Backpressure: result held for five cycles, then back-to-back next op.
    directed(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, "sub_bin");
    hold_result(5);
    check("hold_valid",    bus.out_valid, 1);
    check("hold_in_ready", bus.in_ready,  0);
    check("hold_sum",      {bus.cout, bus.ovf, bus.sum}, {1'b1, 1'b0, 16'h000E});
    take_result();
    directed(16'h2222, 16'h3333, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "back_to_back"); take_result();

    // Asynchronous reset while the third nibble is being processed.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", bus.out_valid, 0);
    check("rst_async_in_ready",  bus.in_ready,  1);
    check("rst_async_sum",       bus.sum,       0);
    check("rst_async_busy",      bus.busy,      0);
    @(posedge clk); #1;
    rst = 1'b0;
    directed(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, "after_reset"); take_result();

    // Randomized traffic, checked by the per-cycle model.
    repeat (40) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      wait_result(1'b0, '0, 1'b0, 1'b0, "rand");
      hold_result($urandom_range(0, 3));
      take_result();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Multi-precision add/subtract sequencer built around one 4-bit full-adder slice. It accepts a WIDTH-bit operand pair over a valid/ready handshake. It then processes one nibble per clock, LSB first, with the carry held in a register between cycles, and presents the result over a valid/ready handshake. It lets the 4-bit ripple adder serve wide datapath operations, trading latency for area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4
NIBBLES, WIDTH/4, derived local constant; number of RUN cycles per operation

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = A+B+cin, 1 = A-B-cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry out; for sub, 1 = no borrow
ovf  output  1  signed (two's complement) overflow
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. Internal operand, carry and index registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid & in_ready, the block captures:
    - a_r = a
    - b_r = sub ? ~b : b
    - carry = cin ^ sub
    - idx = 0
    - sum register cleared
  - Next state is RUN.
- RUN:
  - in_ready=0, busy=1. in_valid is ignored.
  - Each cycle computes {c, s} = a_r[idx] + b_r[idx] + carry, using 4-bit slices with full-adder semantics.
  - Registers update: sum[4*idx+3:4*idx] <= s; carry <= c; idx <= idx+1.
  - When idx == NIBBLES-1:
    - cout <= c
    - ovf <= (a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb), where a_msb = a_r[WIDTH-1], b_msb = b_r[WIDTH-1] (post-inversion) and s_msb = s[3]
    - next state is DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_valid & out_ready, next state is IDLE. out_valid is low and in_ready high from the following cycle.
- Latency:
  - Accept edge at T; out_valid rises after edge T+NIBBLES.
  - Minimum accept-to-accept spacing is NIBBLES+2 cycles: NIBBLES RUN, 1 DONE, 1 IDLE. No same-cycle result-drain/operand-accept bypass.
- Intermediate visibility: sum shows partial results during RUN; it is defined only while out_valid=1.
- Input changes after the accept edge do not affect the operation in flight.
- Arithmetic: result modulo 2^WIDTH. Subtraction with cin=1 computes A-B-1.
- WIDTH=4: NIBBLES=1; a single RUN cycle.
- Reset mid-operation (RUN or DONE):
  - Returns immediately to the reset values.
  - The in-flight transaction is discarded; no out_valid pulse.
  - The next accepted operation is unaffected.
- Handshake rules:
  - out_valid never deasserts without a handshake, except on reset.
  - in_ready and out_valid are never high together.

Test Plan:
(WIDTH=16 unless noted.)
- Add, sub=0, cin=0, 0x1234+0x4321 -> sum=0x5555, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
- Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all nibble boundaries). Add 0x0000+0x0000, cin=1 -> 0x0001.
- Add 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0. Add 0x8000+0x8000 -> sum=0x0000, ovf=1, cout=1.
- Sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000-0x0001 -> sum=0x7FFF, ovf=1, cout=1. Sub 0x0010-0x0001, cin=1 -> 0x000E.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum/cout/ovf stable, in_ready=0.
  - Pulse in_valid with new operands during that window -> ignored.
  - Release out_ready and immediately present the next op -> it is accepted in IDLE, and its result is correct.
- Reset during RUN at idx=2 -> asynchronously out_valid=0, in_ready=1, sum=0, busy=0 with no clock needed. Then 0xABCD+0x1111 -> 0xBCDE, cout=0.
